// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: mux operating mode for the registered
// source-select multiplexers.
package cpu_pkg;

    typedef enum logic {
        MUX_SEL = 1'b0,
        MUX_RR  = 1'b1
    } mux_mode_t;

endpackage

// File: rtl/muxn_registered_rr_arbiter.sv
// Round-robin request arbiter: grants the first requesting channel found when
// scanning upward from ptr, wrapping modulo N.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_idx
);

    function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        sum = (sum >= N) ? (sum - N) : sum;
        return SEL_W'(sum);
    endfunction

    logic [SEL_W-1:0] cand_s;

    // Scan from the farthest offset down so the closest requester to ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_s      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand_s      = wrap_idx(ptr, k);
            grant_idx   = req[cand_s] ? cand_s : grant_idx;
            grant_valid = grant_valid | req[cand_s];
        end
    end

endmodule

// File: rtl/muxn_registered_rr.sv
// N-channel registered multiplexer with valid/ready handshakes, selectable
// between explicit channel select and round-robin arbitration.
module muxn_registered_rr
    import cpu_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               mode,
    input  logic [SEL_W:0]     sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_src,
    output logic               sel_err
);

    logic               mode_rr_s;
    logic               sel_in_range_s;
    logic [SEL_W-1:0]   sel_idx_s;
    logic               rr_valid_s;
    logic [SEL_W-1:0]   rr_idx_s;
    logic               grant_valid_s;
    logic [SEL_W-1:0]   grant_idx_s;
    logic [WIDTH-1:0]   grant_data_s;
    logic [SEL_W-1:0]   ptr_next_s;
    logic               space_s;
    logic               load_s;
    logic               sel_err_s;
    logic [N-1:0]       in_ready_s;

    logic [WIDTH-1:0]   out_r;
    logic               out_valid_r;
    logic [SEL_W-1:0]   out_src_r;
    logic               sel_err_r;
    logic [SEL_W-1:0]   rr_ptr_r;

    assign mode_rr_s      = (mux_mode_t'(mode) == MUX_RR);
    assign sel_in_range_s = (sel < (SEL_W + 1)'(N));
    assign sel_idx_s      = sel[SEL_W-1:0];

    rr_arbiter #(.N(N)) u_arb (
        .req         (in_valid),
        .ptr         (rr_ptr_r),
        .grant_valid (rr_valid_s),
        .grant_idx   (rr_idx_s)
    );

    // Choose the granted channel from either the explicit select or the arbiter.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        if (mode_rr_s) begin
            grant_valid_s = rr_valid_s;
            grant_idx_s   = rr_idx_s;
        end else begin
            grant_valid_s = sel_in_range_s & in_valid[sel_idx_s];
            grant_idx_s   = sel_idx_s;
        end
    end

    assign space_s    = ~out_valid_r | out_ready;
    assign load_s     = wr_en & space_s & grant_valid_s;
    assign sel_err_s  = ~mode_rr_s & ~sel_in_range_s & wr_en & space_s;
    assign ptr_next_s = (grant_idx_s == SEL_W'(N - 1)) ? '0 : grant_idx_s + SEL_W'(1);

    // One-hot accept on the granted channel and the matching data word.
    always_comb begin
        in_ready_s   = '0;
        grant_data_s = '0;
        for (int i = 0; i < N; i++) begin
            in_ready_s[i] = load_s & (grant_idx_s == SEL_W'(i));
            grant_data_s  = grant_data_s
                          | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_idx_s == SEL_W'(i)}});
        end
    end

    // Output register, error pulse and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
            out_src_r   <= '0;
            sel_err_r   <= 1'b0;
            rr_ptr_r    <= '0;
        end else begin
            sel_err_r <= sel_err_s;
            if (load_s) begin
                out_r       <= grant_data_s;
                out_src_r   <= grant_idx_s;
                out_valid_r <= 1'b1;
                rr_ptr_r    <= mode_rr_s ? ptr_next_s : rr_ptr_r;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign out_src   = out_src_r;
    assign sel_err   = sel_err_r;

endmodule

// File: tb/tb_muxn_registered_rr.sv
// Self-checking bench for muxn_registered_rr: per-cycle vector table with a
// scoreboard of loaded words, plus hand sequences for async reset.
module tb_muxn_registered_rr;

    localparam int WIDTH = 8;
    localparam int N     = 4;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic              mode;
    logic [2:0]        sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [WIDTH-1:0]  out;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_src;
    logic              sel_err;

    typedef struct {
        logic       wr_en;
        logic       mode;
        logic [2:0] sel;
        logic [3:0] in_valid;
        logic       out_ready;
        logic [3:0] exp_ready;
        logic       exp_valid;
        logic [7:0] exp_out;
        logic [1:0] exp_src;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] src;
    } sb_t;

    int   errors = 0;
    int   checks = 0;
    vec_t tbl[24];
    sb_t  sb_q[$];
    logic [7:0] chan_data[4];

    muxn_registered_rr #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic we, input logic md, input logic [2:0] s,
                                input logic [3:0] iv, input logic ordy, input logic [3:0] erdy,
                                input logic ev, input logic [7:0] eo, input logic [1:0] es,
                                input logic ee);
        vec_t v;
        v.wr_en = we; v.mode = md; v.sel = s; v.in_valid = iv; v.out_ready = ordy;
        v.exp_ready = erdy; v.exp_valid = ev; v.exp_out = eo; v.exp_src = es; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic md, input logic [2:0] s,
                         input logic [3:0] iv, input logic ordy);
        wr_en = we; mode = md; sel = s; in_valid = iv; out_ready = ordy;
    endtask

    initial begin
        chan_data[0] = 8'd11; chan_data[1] = 8'd12; chan_data[2] = 8'd13; chan_data[3] = 8'd14;
        in_data = {8'd14, 8'd13, 8'd12, 8'd11};
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 4'b0000, 1'b1);

        //              we    md    sel   in_valid  ordy  exp_rdy   ev    out    src   err
        tbl[0]  = mk(1'b1, 1'b0, 3'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'd12, 2'd1, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 3'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'd13, 2'd2, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 3'd4, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'd13, 2'd2, 1'b1);
        tbl[3]  = mk(1'b1, 1'b0, 3'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd13, 2'd2, 1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 3'd4, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'd13, 2'd2, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 3'd7, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'd13, 2'd2, 1'b1);
        tbl[6]  = mk(1'b1, 1'b0, 3'd0, 4'b1110, 1'b1, 4'b0000, 1'b0, 8'd13, 2'd2, 1'b0);
        tbl[7]  = mk(1'b1, 1'b1, 3'd4, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'd11, 2'd0, 1'b0);
        tbl[8]  = mk(1'b1, 1'b1, 3'd4, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'd12, 2'd1, 1'b0);
        tbl[9]  = mk(1'b1, 1'b1, 3'd4, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'd13, 2'd2, 1'b0);
        tbl[10] = mk(1'b1, 1'b1, 3'd4, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'd14, 2'd3, 1'b0);
        tbl[11] = mk(1'b1, 1'b1, 3'd4, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'd11, 2'd0, 1'b0);
        tbl[12] = mk(1'b1, 1'b1, 3'd4, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'd12, 2'd1, 1'b0);
        tbl[13] = mk(1'b1, 1'b1, 3'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'd14, 2'd3, 1'b0);
        tbl[14] = mk(1'b1, 1'b1, 3'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'd12, 2'd1, 1'b0);
        tbl[15] = mk(1'b1, 1'b1, 3'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'd14, 2'd3, 1'b0);
        tbl[16] = mk(1'b1, 1'b1, 3'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'd14, 2'd3, 1'b0);
        tbl[17] = mk(1'b1, 1'b1, 3'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'd14, 2'd3, 1'b0);
        tbl[18] = mk(1'b1, 1'b1, 3'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'd14, 2'd3, 1'b0);
        tbl[19] = mk(1'b1, 1'b1, 3'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'd11, 2'd0, 1'b0);
        tbl[20] = mk(1'b1, 1'b0, 3'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'd14, 2'd3, 1'b0);
        tbl[21] = mk(1'b1, 1'b1, 3'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'd12, 2'd1, 1'b0);
        tbl[22] = mk(1'b1, 1'b0, 3'd5, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'd12, 2'd1, 1'b0);
        tbl[23] = mk(1'b1, 1'b0, 3'd5, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'd12, 2'd1, 1'b1);

        // Reset state before any clock edge.
        #2;
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_src", 32'(out_src), 32'd0);
        chk("reset_err", 32'(sel_err), 32'd0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 24; t++) begin
            drive(tbl[t].wr_en, tbl[t].mode, tbl[t].sel, tbl[t].in_valid, tbl[t].out_ready);
            #1;
            chk($sformatf("in_ready[%0d]", t), 32'(in_ready), 32'(tbl[t].exp_ready));
            for (int i = 0; i < N; i++) begin
                if (tbl[t].exp_ready[i]) sb_q.push_back('{data: chan_data[i], src: 2'(i)});
            end
            @(posedge clk); #1;
            chk($sformatf("out_valid[%0d]", t), 32'(out_valid), 32'(tbl[t].exp_valid));
            chk($sformatf("out[%0d]", t), 32'(out), 32'(tbl[t].exp_out));
            chk($sformatf("out_src[%0d]", t), 32'(out_src), 32'(tbl[t].exp_src));
            chk($sformatf("sel_err[%0d]", t), 32'(sel_err), 32'(tbl[t].exp_err));
            if (tbl[t].exp_ready != 4'b0000) begin
                if (sb_q.size() == 0) begin
                    chk($sformatf("sb_empty[%0d]", t), 32'd0, 32'd1);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk($sformatf("sb_data[%0d]", t), 32'(out), 32'(e.data));
                    chk($sformatf("sb_src[%0d]", t), 32'(out_src), 32'(e.src));
                end
            end
        end
        chk("sb_leftover", 32'(sb_q.size()), 32'd0);

        // Mid-stream async reset: outputs clear before the next edge.
        drive(1'b1, 1'b0, 3'd0, 4'b1111, 1'b1);
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_out", 32'(out), 32'd11);
        wr_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_out", 32'(out), 32'd0);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_src", 32'(out_src), 32'd0);
        chk("async_rst_err", 32'(sel_err), 32'd0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        // Round-robin pointer restarts at channel 0 after reset.
        drive(1'b1, 1'b1, 3'd0, 4'b1111, 1'b1);
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("post_rst_out", 32'(out), 32'd11);
        chk("post_rst_src", 32'(out_src), 32'd0);
        chk("post_rst_valid", 32'(out_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
